spi_xfer_ctrl: RTL and testbench

Transaction sequencer and two-port arbiter for the shared SPI shift engines: the `mosi` transmitter and the `miso` receiver. It accepts 32-bit transfer requests from two requesters (port 0 is the CPU, port 1 is the debug/DMA port) and grants them round-robin. For each granted request it frames the transfer with chip-select, starts both engines in lockstep, waits for completion and returns the received word with a response pulse.

---
 rtl/spi_xfer_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: round-robin arbiter and transaction sequencer for the shared
// SPI shift engines (mosi transmitter, miso receiver). Two requesters, one
// transfer in flight, chip-select framing and a response pulse per transfer.
// Optional SHIFT watchdog is built when SPI_CTRL_TIMEOUT_EN is defined.
module spi_xfer_ctrl #(
   parameter int unsigned W_CPU   = 32,
   parameter int unsigned W_Data  = W_CPU,
   parameter int unsigned CS_GAP  = 2,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   input  logic              req0_read,
   input  logic [W_Data-1:0] req0_wdata,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic              req1_read,
   input  logic [W_Data-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              resp_valid,
   output logic              resp_id,
   output logic [W_Data-1:0] resp_rdata,
   output logic              resp_err,
   output logic              spi_cs_n,
   output logic              tx_valid,
   output logic [W_Data-1:0] tx_data,
   input  logic              tx_ready,
   output logic              rx_start,
   input  logic              rx_ready,
   input  logic [W_Data-1:0] rx_data,
   output logic              busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_ISSUE  = 3'd2;
   localparam logic [2:0] S_SHIFT  = 3'd3;
   localparam logic [2:0] S_FINISH = 3'd4;
   localparam logic [2:0] S_GAP    = 3'd5;

   // GAP counts down from CS_GAP-1 to 0, giving exactly CS_GAP cycles in GAP
   localparam logic [3:0] GAP_LOAD = (CS_GAP > 0) ? 4'(CS_GAP - 1) : 4'd0;

   logic [2:0]        state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              cur_read_q, cur_read_d;
   logic              cur_id_q, cur_id_d;
   logic [W_Data-1:0] tx_data_q, tx_data_d;
   logic [W_Data-1:0] rdata_q, rdata_d;
   logic              seen_busy_q, seen_busy_d;
   logic [3:0]        gap_cnt_q, gap_cnt_d;
   logic              done_ok;
   logic              grant;
   logic              accept_ok;

`ifdef SPI_CTRL_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wd_q, wd_d;
   logic       err_q, err_d;
`else
   // TIMEOUT only matters when the watchdog is built
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
`endif

   // readies are also held low while reset is asserted, not just in non-IDLE states
   assign accept_ok = (state_q == S_IDLE) && rst;
   assign done_ok   = seen_busy_q && tx_ready && (!cur_read_q || rx_ready);

   // round-robin pick: on conflict the port not granted last time wins
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end
   end

   assign req0_ready = accept_ok && req0_valid && !grant;
   assign req1_ready = accept_ok && req1_valid && grant;

   // next-state and datapath capture for the transfer sequence
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cur_read_d   = cur_read_q;
      cur_id_d     = cur_id_q;
      tx_data_d    = tx_data_q;
      rdata_d      = rdata_q;
      seen_busy_d  = seen_busy_q;
      gap_cnt_d    = gap_cnt_q;
`ifdef SPI_CTRL_TIMEOUT_EN
      wd_d         = wd_q;
      err_d        = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req0_ready || req1_ready) begin
               state_d      = S_SETUP;
               cur_id_d     = grant;
               cur_read_d   = grant ? req1_read  : req0_read;
               tx_data_d    = grant ? req1_wdata : req0_wdata;
               last_grant_d = grant;
            end
         end
         S_SETUP: state_d = S_ISSUE;
         S_ISSUE: begin
            seen_busy_d = 1'b0;
`ifdef SPI_CTRL_TIMEOUT_EN
            wd_d        = '0;
`endif
            state_d     = S_SHIFT;
         end
         S_SHIFT: begin
            if (!tx_ready) begin
               seen_busy_d = 1'b1;
            end
            if (done_ok) begin
               state_d = S_FINISH;
               rdata_d = cur_read_q ? rx_data : '0;
`ifdef SPI_CTRL_TIMEOUT_EN
               err_d   = 1'b0;
            end else if (wd_q == TO_LAST) begin
               state_d = S_FINISH;
               rdata_d = '0;
               err_d   = 1'b1;
            end else begin
               wd_d    = wd_q + 8'd1;
`endif
            end
         end
         S_FINISH: begin
            if (CS_GAP > 0) begin
               state_d   = S_GAP;
               gap_cnt_d = GAP_LOAD;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == 4'd0) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         cur_read_q   <= 1'b0;
         cur_id_q     <= 1'b0;
         tx_data_q    <= '0;
         rdata_q      <= '0;
         seen_busy_q  <= 1'b0;
         gap_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cur_read_q   <= cur_read_d;
         cur_id_q     <= cur_id_d;
         tx_data_q    <= tx_data_d;
         rdata_q      <= rdata_d;
         seen_busy_q  <= seen_busy_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

`ifdef SPI_CTRL_TIMEOUT_EN
   // watchdog counter and abort flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         wd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         wd_q  <= wd_d;
         err_q <= err_d;
      end
   end
   assign resp_err = (state_q == S_FINISH) && err_q;
`else
   assign resp_err = 1'b0;
`endif

   assign spi_cs_n   = !((state_q == S_SETUP) || (state_q == S_ISSUE) || (state_q == S_SHIFT));
   assign tx_valid   = (state_q == S_ISSUE);
   assign rx_start   = (state_q == S_ISSUE) && cur_read_q;
   assign resp_valid = (state_q == S_FINISH);
   assign resp_id    = (state_q == S_FINISH) && cur_id_q;
   assign resp_rdata = rdata_q;
   assign tx_data    = tx_data_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Scoreboard bench for spi_xfer_ctrl with a simple mosi/miso engine model.
module tb_spi_xfer_ctrl;
   localparam int unsigned CS_GAP  = 2;
   localparam int unsigned TIMEOUT = 64;
   localparam int N_TX = 8;
   localparam int N_RX = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_valid = 1'b0, req0_read = 1'b0;
   logic [31:0] req0_wdata = '0;
   logic        req0_ready;
   logic        req1_valid = 1'b0, req1_read = 1'b0;
   logic [31:0] req1_wdata = '0;
   logic        req1_ready;
   logic        resp_valid, resp_id, resp_err;
   logic [31:0] resp_rdata;
   logic        spi_cs_n, tx_valid, rx_start, busy;
   logic [31:0] tx_data;
   logic        tx_ready = 1'b1;
   logic        rx_ready = 1'b1;
   logic [31:0] rx_data  = '0;

   always #5 clk = ~clk;

   spi_xfer_ctrl #(.W_Data(32), .CS_GAP(CS_GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_read(req0_read), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_read(req1_read), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .spi_cs_n(spi_cs_n), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .rx_start(rx_start), .rx_ready(rx_ready), .rx_data(rx_data), .busy(busy)
   );

   typedef struct packed { logic [31:0] wdata; logic read; } tx_exp_t;
   typedef struct packed { logic id; logic [31:0] rdata; logic err; } resp_exp_t;
   tx_exp_t   tx_q[$];
   resp_exp_t resp_q[$];

   int checks = 0, errors = 0;
   int cyc = 0;
   int tx_cnt = 0, rx_cnt = 0, resp_cnt = 0, tx_cyc = 0;
   int tcnt = 0, rcnt = 0;
   int hi_run = 0, gap_seen = 0;
   bit low_seen = 0, gap_en = 0;
   logic stall = 1'b0;
   logic [31:0] rx_word = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // engine model: tx busy N_TX cycles after start; rx busy N_RX cycles then presents rx_word
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tx_valid === 1'b1) begin
            tx_ready = 1'b0;
            tcnt = N_TX;
         end else if (tcnt > 0 && !stall) begin
            tcnt--;
            if (tcnt == 0) tx_ready = 1'b1;
         end
         if (rx_start === 1'b1) begin
            rx_ready = 1'b0;
            rcnt = N_RX;
            rx_data = '0;
         end else if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin
               rx_ready = 1'b1;
               rx_data = rx_word;
            end
         end
      end
   end

   // monitor: pops the scoreboard whenever the DUT starts a transfer or responds
   always @(negedge clk) begin
      tx_exp_t   te;
      resp_exp_t re;
      if (tx_valid === 1'b1) begin
         tx_cnt++;
         tx_cyc = cyc;
         if (rx_start === 1'b1) rx_cnt++;
         if (tx_q.size() == 0) begin
            fail_now("unexpected_tx_valid");
         end else begin
            te = tx_q.pop_front();
            chk("tx_data", tx_data, te.wdata);
            chk("rx_start", {31'd0, rx_start}, {31'd0, te.read});
            chk("cs_low_at_issue", {31'd0, spi_cs_n}, 32'd0);
         end
      end
      if (resp_valid === 1'b1) begin
         resp_cnt++;
         if (resp_q.size() == 0) begin
            fail_now("unexpected_resp_valid");
         end else begin
            re = resp_q.pop_front();
            chk("resp_id", {31'd0, resp_id}, {31'd0, re.id});
            chk("resp_rdata", resp_rdata, re.rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, re.err});
            chk("cs_high_at_finish", {31'd0, spi_cs_n}, 32'd1);
            if (re.err) chk("timeout_latency", 32'(cyc - tx_cyc), TIMEOUT + 1);
         end
      end
      // high run between two low periods: FINISH + CS_GAP GAP cycles + IDLE
      if (!gap_en) begin
         low_seen = 0;
         hi_run = 0;
      end else if (spi_cs_n === 1'b1) begin
         hi_run++;
      end else begin
         if (low_seen && hi_run > 0) begin
            chk("cs_high_gap", 32'(hi_run), CS_GAP + 2);
            gap_seen++;
         end
         low_seen = 1;
         hi_run = 0;
      end
   end

   task automatic push(input logic [31:0] wd, input logic rd, input logic id, input logic [31:0] rdata, input logic err);
      tx_q.push_back('{wdata: wd, read: rd});
      resp_q.push_back('{id: id, rdata: rdata, err: err});
   endtask

   task automatic set_req(input int p, input logic v, input logic rd, input logic [31:0] wd);
      if (p == 0) begin
         req0_valid = v; req0_read = rd; req0_wdata = wd;
      end else begin
         req1_valid = v; req1_read = rd; req1_wdata = wd;
      end
   endtask

   // hold a request until accepted, then check SETUP/ISSUE latency
   task automatic issue(input int p, input logic rd, input logic [31:0] wd);
      bit done = 0;
      logic rdy;
      @(negedge clk);
      set_req(p, 1'b1, rd, wd);
      for (int i = 0; i < 400 && !done; i++) begin
         #1;
         rdy = (p == 0) ? req0_ready : req1_ready;
         if (rdy === 1'b1) begin
            @(posedge clk);
            #1;
            set_req(p, 1'b0, rd, wd);
            chk($sformatf("cs_low_after_accept_p%0d", p), {31'd0, spi_cs_n}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("tx_valid_after_accept_p%0d", p), {31'd0, tx_valid}, 32'd1);
            done = 1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         set_req(p, 1'b0, rd, wd);
         fail_now($sformatf("accept_timeout_p%0d", p));
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((tx_q.size() != 0 || resp_q.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(tx_q.size() + resp_q.size()), 32'd0);
      repeat (CS_GAP + 4) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit");
      $fatal(1, "time limit");
   end

   initial begin
      // reset defaults with both requesters pushing
      rst = 1'b0;
      set_req(0, 1'b1, 1'b1, 32'h1111_1111);
      set_req(1, 1'b1, 1'b0, 32'h2222_2222);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
         chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
         chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
         chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
         chk("rst_busy", {31'd0, busy}, 32'd0);
         chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
         chk("rst_tx_data", tx_data, 32'd0);
         chk("rst_resp_rdata", resp_rdata, 32'd0);
      end
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, '0);
      set_req(1, 1'b0, 1'b0, '0);
      rst = 1'b1;

      // single read from port 0
      rx_word = 32'h1234_5678;
      tx_cnt = 0; rx_cnt = 0;
      push(32'hA5A5_0F0F, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
      issue(0, 1'b1, 32'hA5A5_0F0F);
      drain("drain_read");
      chk("read_tx_pulses", 32'(tx_cnt), 32'd1);
      chk("read_rx_pulses", 32'(rx_cnt), 32'd1);

      // write only from port 1
      tx_cnt = 0; rx_cnt = 0;
      push(32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b0);
      issue(1, 1'b0, 32'hDEAD_BEEF);
      drain("drain_write");
      chk("write_tx_pulses", 32'(tx_cnt), 32'd1);
      chk("write_rx_pulses", 32'(rx_cnt), 32'd0);

      // arbitration from reset: both ports always valid, expect 0,1,0,1
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      rx_word = 32'hCAFE_0001;
      gap_seen = 0;
      push(32'h1111_0000, 1'b1, 1'b0, 32'hCAFE_0001, 1'b0);
      push(32'h2222_0000, 1'b0, 1'b1, 32'h0, 1'b0);
      push(32'h1111_0001, 1'b1, 1'b0, 32'hCAFE_0001, 1'b0);
      push(32'h2222_0001, 1'b0, 1'b1, 32'h0, 1'b0);
      gap_en = 1;
      fork
         begin
            issue(0, 1'b1, 32'h1111_0000);
            issue(0, 1'b1, 32'h1111_0001);
         end
         begin
            issue(1, 1'b0, 32'h2222_0000);
            issue(1, 1'b0, 32'h2222_0001);
         end
      join
      drain("drain_arb");
      gap_en = 0;
      chk("gap_periods_seen", 32'(gap_seen), 32'd3);

      // reset during SHIFT: request is dropped, no response
      tx_q.push_back('{wdata: 32'h5555_AAAA, read: 1'b1});
      issue(0, 1'b1, 32'h5555_AAAA);
      repeat (3) @(negedge clk);
      resp_cnt = 0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_cs_n", {31'd0, spi_cs_n}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      chk("abort_no_resp", 32'(resp_cnt), 32'd0);
      chk("abort_tx_q_empty", 32'(tx_q.size()), 32'd0);
      rx_word = 32'h0BAD_F00D;
      push(32'h7777_0007, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0);
      issue(1, 1'b1, 32'h7777_0007);
      drain("drain_after_abort");

`ifdef SPI_CTRL_TIMEOUT_EN
      // engine never completes: watchdog aborts with an error response
      stall = 1'b1;
      rx_word = 32'hFFFF_0000;
      push(32'h0F0F_F0F0, 1'b1, 1'b0, 32'h0, 1'b1);
      issue(0, 1'b1, 32'h0F0F_F0F0);
      drain("drain_timeout");
      stall = 1'b0;
      repeat (N_TX + 4) @(negedge clk);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
